hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Next-generation hazard/forwarding unit for the 5-stage core: address width is parametrised, and it adds a sequential structural-hazard tracker for a multi-cycle MUL/DIV unit (HI/LO).
- Sits beside the datapath. It takes decode/execute/memory/writeback register fields and drives the stall, flush and forward selects.
- It also keeps a saturating stall-cycle counter and a registered last-stall cause for the perf/debug CSRs.

Parameters:
- AW, 5, register-address width (register 0 is hard-wired zero and never forwarded or hazard-checked).
- MD_LAT, 32, MUL/DIV busy cycles after issue (>=1).
- CNT_W, 32, stall-counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rs_d, rt_d  in  AW  decode source registers
- branch_d  in  1  decode instruction is a compare-in-decode branch
- jr_d  in  1  decode instruction is jr/jalr (reads rs_d)
- md_start_d  in  1  decode instruction starts MUL/DIV
- mfhilo_d  in  1  decode instruction reads HI/LO
- rs_e, rt_e, wa_e  in  AW  execute sources / dest
- we_e, load_e  in  1  execute writes register / is load
- wa_m  in  AW  memory dest
- we_m, load_m  in  1  memory writes register / is load
- wa_w  in  AW  writeback dest
- we_w  in  1  writeback writes register
- stall_f, stall_d, flush_e  out  1  pipeline control
- forward_ae, forward_be  out  2  EX operand select: 10=MEM, 01=WB, 00=regfile
- forward_ad, forward_bd  out  1  decode branch-compare forward from MEM
- md_busy  out  1  MUL/DIV in flight
- stall_cnt  out  CNT_W  total stalled cycles, saturating
- stall_cause  out  3  cause of the most recent stall: {md, ctrl, load}

Behaviour:

Forwarding (combinational):
- forward_ae = 10 if rs_e!=0 && rs_e==wa_m && we_m; else 01 if rs_e!=0 && rs_e==wa_w && we_w; else 00. MEM has priority over WB.
- forward_be uses the same rule with rt_e.
- forward_ad = rs_d!=0 && rs_d==wa_m && we_m && !load_m. forward_bd is the same rule with rt_d.

Stall sources (combinational), each match requiring the compared source to be nonzero:
- load_stall: load_e && wa_e!=0 && (wa_e==rs_d || wa_e==rt_d).
- ctrl_stall covers two cases:
  - (branch_d||jr_d) && we_e && wa_e matches a used source. Branch uses rs_d and rt_d; jr uses rs_d only.
  - (branch_d||jr_d) && load_m && wa_m matches a used source.
- md_stall: md_busy && (mfhilo_d || md_start_d).
- stall = load_stall | ctrl_stall | md_stall. stall_f = stall_d = flush_e = stall.

MUL/DIV counter (md_cnt, width clog2(MD_LAT+1)):
- Reset value 0. md_busy = (md_cnt != 0).
- md_start_d && !stall at edge t: md_cnt = MD_LAT after t. md_busy is high for exactly MD_LAT cycles.
- Otherwise, if md_cnt != 0, decrement by 1.
- A start blocked by any stall source does not load. A start during busy stalls; it is accepted on the cycle md_cnt reaches 0.
- Back-to-back: acceptance on the cycle md_busy is low reloads MD_LAT with no idle gap.

Perf/debug registers:
- stall_cnt increments on every clk with stall high and saturates at all-ones (no wrap).
- stall_cause loads {md_stall, ctrl_stall, load_stall} on every stall cycle and holds otherwise. Simultaneous causes set multiple bits.

Reset:
- rst_n low clears md_cnt, stall_cnt and stall_cause immediately.
- An in-flight MUL/DIV is abandoned; the datapath unit is reset by the same rst_n.
- Outputs after reset: md_busy=0, stall_cnt=0, stall_cause=000. Combinational outputs follow their inputs.

Decomposition:
- Shared package core_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - A stall_cause_t packed struct {md, ctrl, load}.
- One natural sub-module: md_busy_tracker, holding md_cnt, its load/decrement and md_busy.
- The forwarding and stall equations stay in the top module.

Test Plan:
- rs_e=3, wa_m=3, we_m=1, wa_w=3, we_w=1 -> forward_ae=10. With we_m=0 -> 01. With rs_e=0 -> 00.
- load_e=1, wa_e=7, rt_d=7 -> stall_f=stall_d=flush_e=1 for one cycle; stall_cnt +1; stall_cause=001. With wa_e=0 -> no stall.
- branch_d=1, rs_d=4, load_m=1, wa_m=4 -> stall, forward_ad=0. With load_m=0, we_m=1 -> no stall, forward_ad=1.
- MD_LAT=4: md_start_d at cycle 0 -> md_busy cycles 1-4. mfhilo_d held from cycle 1 -> stall cycles 1-4, released cycle 5; stall_cause=100.
- md_start_d coincident with load_stall -> not accepted, md_busy stays 0. Accepted the next unstalled cycle.
- CNT_W=3, hold stall for 10 cycles -> stall_cnt saturates at 7. Then rst_n pulsed low mid-MUL/DIV -> md_busy=0, stall_cnt=0 asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the core's hazard and forwarding logic.
package core_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic md;
        logic ctrl;
        logic load;
    } stall_cause_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks the multi-cycle MUL/DIV unit: busy for MD_LAT cycles after an accepted start.
module md_busy_tracker #(
    parameter int MD_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic md_busy
);

    localparam int CW = $clog2(MD_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(MD_LAT);

    logic [CW-1:0] md_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (start) begin
            md_cnt <= LAT;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CW'(1);
        end
    end

    assign md_busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit for the 5-stage core with MUL/DIV tracking
// and perf counters for stall cycles and last stall cause.
module hazard_scoreboard
    import core_pkg::*;
#(
    parameter int AW     = 5,
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rs_d,
    input  logic [AW-1:0]    rt_d,
    input  logic             branch_d,
    input  logic             jr_d,
    input  logic             md_start_d,
    input  logic             mfhilo_d,
    input  logic [AW-1:0]    rs_e,
    input  logic [AW-1:0]    rt_e,
    input  logic [AW-1:0]    wa_e,
    input  logic             we_e,
    input  logic             load_e,
    input  logic [AW-1:0]    wa_m,
    input  logic             we_m,
    input  logic             load_m,
    input  logic [AW-1:0]    wa_w,
    input  logic             we_w,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             forward_ad,
    output logic             forward_bd,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [2:0]       stall_cause
);

    logic         rs_nz, rt_nz;
    logic         rs_used, rt_used;
    logic         load_stall, ctrl_stall, md_stall, stall;
    logic         ctrl_e_hit, ctrl_m_hit;
    stall_cause_t cause_q;

    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] src,
        input logic [AW-1:0] am,
        input logic          wm,
        input logic [AW-1:0] aw,
        input logic          ww
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != '0 && src == am && wm) begin
            sel = FWD_MEM;
        end else if (src != '0 && src == aw && ww) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign forward_ae = fwd_sel(rs_e, wa_m, we_m, wa_w, we_w);
    assign forward_be = fwd_sel(rt_e, wa_m, we_m, wa_w, we_w);

    // Loads in MEM cannot forward to decode: data arrives too late.
    assign forward_ad = (rs_d != '0) && (rs_d == wa_m) && we_m && !load_m;
    assign forward_bd = (rt_d != '0) && (rt_d == wa_m) && we_m && !load_m;

    assign rs_nz   = (rs_d != '0);
    assign rt_nz   = (rt_d != '0);
    assign rs_used = branch_d | jr_d;
    assign rt_used = branch_d;

    assign load_stall = load_e && (wa_e != '0) &&
                        ((rs_nz && wa_e == rs_d) || (rt_nz && wa_e == rt_d));

    assign ctrl_e_hit = we_e &&
                        ((rs_used && rs_nz && wa_e == rs_d) ||
                         (rt_used && rt_nz && wa_e == rt_d));
    assign ctrl_m_hit = load_m &&
                        ((rs_used && rs_nz && wa_m == rs_d) ||
                         (rt_used && rt_nz && wa_m == rt_d));
    assign ctrl_stall = (branch_d | jr_d) && (ctrl_e_hit || ctrl_m_hit);

    assign md_stall = md_busy && (mfhilo_d || md_start_d);

    assign stall   = load_stall | ctrl_stall | md_stall;
    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

    md_busy_tracker #(
        .MD_LAT (MD_LAT)
    ) u_md (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (md_start_d && !stall),
        .md_busy (md_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            cause_q   <= '0;
        end else if (stall) begin
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            cause_q <= '{md: md_stall, ctrl: ctrl_stall, load: load_stall};
        end
    end

    assign stall_cause = cause_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard with a queue-based scoreboard.
module tb_hazard_scoreboard;

    localparam int AW     = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 3;
    localparam int CMAX   = 7;

    typedef struct {
        logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
        logic branch_d, jr_d, md_start_d, mfhilo_d;
        logic we_e, load_e, we_m, load_m, we_w;
    } in_t;

    typedef struct {
        logic [1:0] fae, fbe;
        logic       fad, fbd, stall, busy;
        logic [2:0] cnt, cause;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] rs_d = '0, rt_d = '0, rs_e = '0, rt_e = '0;
    logic [AW-1:0] wa_e = '0, wa_m = '0, wa_w = '0;
    logic branch_d = 0, jr_d = 0, md_start_d = 0, mfhilo_d = 0;
    logic we_e = 0, load_e = 0, we_m = 0, load_m = 0, we_w = 0;
    logic stall_f, stall_d, flush_e, forward_ad, forward_bd, md_busy;
    logic [1:0] forward_ae, forward_be;
    logic [CNT_W-1:0] stall_cnt;
    logic [2:0] stall_cause;

    int checks = 0;
    int failures = 0;
    exp_t q[$];
    exp_t me;

    int cyc = 0;
    int md_end = 0;
    int scount = 0;
    logic [2:0] cause_m = 3'b000;

    hazard_scoreboard #(.AW(AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .jr_d(jr_d),
        .md_start_d(md_start_d), .mfhilo_d(mfhilo_d),
        .rs_e(rs_e), .rt_e(rt_e), .wa_e(wa_e), .we_e(we_e), .load_e(load_e),
        .wa_m(wa_m), .we_m(we_m), .load_m(load_m),
        .wa_w(wa_w), .we_w(we_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .forward_ae(forward_ae), .forward_be(forward_be),
        .forward_ad(forward_ad), .forward_bd(forward_bd),
        .md_busy(md_busy), .stall_cnt(stall_cnt), .stall_cause(stall_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    function automatic in_t zin();
        in_t x;
        x.rs_d = '0; x.rt_d = '0; x.rs_e = '0; x.rt_e = '0;
        x.wa_e = '0; x.wa_m = '0; x.wa_w = '0;
        x.branch_d = 0; x.jr_d = 0; x.md_start_d = 0; x.mfhilo_d = 0;
        x.we_e = 0; x.load_e = 0; x.we_m = 0; x.load_m = 0; x.we_w = 0;
        return x;
    endfunction

    function automatic in_t rin();
        in_t x;
        x.rs_d = AW'($urandom_range(0, 3)); x.rt_d = AW'($urandom_range(0, 3));
        x.rs_e = AW'($urandom_range(0, 3)); x.rt_e = AW'($urandom_range(0, 3));
        x.wa_e = AW'($urandom_range(0, 3)); x.wa_m = AW'($urandom_range(0, 3));
        x.wa_w = AW'($urandom_range(0, 3));
        x.branch_d = ($urandom_range(0, 3) == 0);
        x.jr_d = ($urandom_range(0, 5) == 0);
        x.md_start_d = ($urandom_range(0, 5) == 0);
        x.mfhilo_d = ($urandom_range(0, 4) == 0);
        x.we_e = $urandom_range(0, 1); x.load_e = ($urandom_range(0, 3) == 0);
        x.we_m = $urandom_range(0, 1); x.load_m = ($urandom_range(0, 3) == 0);
        x.we_w = $urandom_range(0, 1);
        return x;
    endfunction

    function automatic logic [1:0] ref_fwd(input in_t x, input logic [AW-1:0] s);
        if (s != 0 && s == x.wa_m && x.we_m) return 2'd2;
        if (s != 0 && s == x.wa_w && x.we_w) return 2'd1;
        return 2'd0;
    endfunction

    // A decode source "reads" register r when it is nonzero and named by the instruction.
    function automatic bit reads(input in_t x, input logic [AW-1:0] r, input bit rs_ok, input bit rt_ok);
        if (r == 0) return 0;
        return (rs_ok && x.rs_d == r) || (rt_ok && x.rt_d == r);
    endfunction

    task automatic step(input in_t x);
        exp_t e;
        bit ld, ct, md, st, busy, cf;
        @(posedge clk);
        #2;
        rs_d = x.rs_d; rt_d = x.rt_d; rs_e = x.rs_e; rt_e = x.rt_e;
        wa_e = x.wa_e; wa_m = x.wa_m; wa_w = x.wa_w;
        branch_d = x.branch_d; jr_d = x.jr_d;
        md_start_d = x.md_start_d; mfhilo_d = x.mfhilo_d;
        we_e = x.we_e; load_e = x.load_e; we_m = x.we_m;
        load_m = x.load_m; we_w = x.we_w;

        busy = (cyc < md_end);
        cf = x.branch_d || x.jr_d;
        ld = x.load_e && reads(x, x.wa_e, 1, 1);
        ct = cf && ((x.we_e && reads(x, x.wa_e, 1, x.branch_d)) ||
                    (x.load_m && reads(x, x.wa_m, 1, x.branch_d)));
        md = busy && (x.mfhilo_d || x.md_start_d);
        st = ld || ct || md;

        e.fae = ref_fwd(x, x.rs_e);
        e.fbe = ref_fwd(x, x.rt_e);
        e.fad = x.rs_d != 0 && x.rs_d == x.wa_m && x.we_m && !x.load_m;
        e.fbd = x.rt_d != 0 && x.rt_d == x.wa_m && x.we_m && !x.load_m;
        e.stall = st;
        e.busy = busy;
        e.cnt = 3'((scount > CMAX) ? CMAX : scount);
        e.cause = cause_m;
        q.push_back(e);

        if (st) begin
            scount++;
            cause_m = {md, ct, ld};
        end
        if (x.md_start_d && !st) md_end = cyc + 1 + MD_LAT;
        cyc++;
    endtask

    task automatic do_reset();
        in_t z;
        z = zin();
        @(posedge clk);
        #2;
        rs_d = z.rs_d; rt_d = z.rt_d; wa_e = z.wa_e; wa_m = z.wa_m;
        branch_d = 0; jr_d = 0; md_start_d = 0; mfhilo_d = 0;
        load_e = 0; load_m = 0; we_e = 0; we_m = 0; we_w = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_md_busy", 32'(md_busy), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_stall_cause", 32'(stall_cause), 0);
        @(negedge clk);
        rst_n = 1'b1;
        md_end = 0;
        scount = 0;
        cause_m = 3'b000;
        cyc++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("forward_ae", 32'(forward_ae), 32'(me.fae));
            chk("forward_be", 32'(forward_be), 32'(me.fbe));
            chk("forward_ad", 32'(forward_ad), 32'(me.fad));
            chk("forward_bd", 32'(forward_bd), 32'(me.fbd));
            chk("stall_f", 32'(stall_f), 32'(me.stall));
            chk("stall_d", 32'(stall_d), 32'(me.stall));
            chk("flush_e", 32'(flush_e), 32'(me.stall));
            chk("md_busy", 32'(md_busy), 32'(me.busy));
            chk("stall_cnt", 32'(stall_cnt), 32'(me.cnt));
            chk("stall_cause", 32'(stall_cause), 32'(me.cause));
        end
    end

    initial begin
        in_t x;
        repeat (2) @(posedge clk);
        do_reset();

        x = zin();
        x.rs_e = 3; x.wa_m = 3; x.we_m = 1; x.wa_w = 3; x.we_w = 1;
        step(x);
        x.we_m = 0; step(x);
        x.rs_e = 0; step(x);

        x = zin();
        x.load_e = 1; x.wa_e = 7; x.rt_d = 7;
        step(x);
        x.wa_e = 0; step(x);

        x = zin();
        x.branch_d = 1; x.rs_d = 4; x.load_m = 1; x.wa_m = 4;
        step(x);
        x.load_m = 0; x.we_m = 1; step(x);

        x = zin();
        x.md_start_d = 1; step(x);
        x = zin();
        x.mfhilo_d = 1;
        repeat (5) step(x);
        step(zin());

        x = zin();
        x.md_start_d = 1; x.load_e = 1; x.wa_e = 5; x.rs_d = 5;
        step(x);
        x = zin();
        x.md_start_d = 1; step(x);
        repeat (5) step(zin());

        x = zin();
        x.md_start_d = 1;
        repeat (12) step(x);

        x = zin();
        x.load_e = 1; x.wa_e = 7; x.rt_d = 7;
        repeat (10) step(x);

        x = zin();
        x.md_start_d = 1; step(x);
        repeat (2) step(zin());
        do_reset();
        step(zin());

        for (int i = 0; i < 400; i++) begin
            step(rin());
            if (i == 200) do_reset();
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
